// File: rtl/opb_register_simulink2ppc_snap_pkg.sv
// rtl/opb_register_simulink2ppc_snap_pkg.sv - register map, bit positions and bus FSM states
package opb_register_simulink2ppc_snap_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;

    localparam logic [1:0] WORD_DATA   = REG_DATA[3:2];
    localparam logic [1:0] WORD_STATUS = REG_STATUS[3:2];
    localparam logic [1:0] WORD_CTRL   = REG_CTRL[3:2];

    localparam int STAT_VALID_BIT = 0;
    localparam int STAT_OVF_BIT   = 1;
    localparam int STAT_ARMED_BIT = 2;
    localparam int STAT_COUNT_LSB = 16;

    localparam int CTRL_ARM_BIT   = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    localparam int COUNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } ack_state_t;

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// rtl/opb_slave_ack_fsm.sv - address decode and single-shot OPB acknowledge sequencer
module opb_slave_ack_fsm
    import opb_register_simulink2ppc_snap_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0100B100,
    parameter logic [31:0] HIGH_ADDR = 32'h0100B1FF
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        select,
    input  logic [31:0] addr,
    input  logic        rnw,
    output logic        load_strobe,
    output logic        ack,
    output logic        rnw_q,
    output logic [1:0]  word_off_q
);

    ack_state_t state_q, state_nxt;
    logic       hit;

    assign hit = select && (addr >= BASE_ADDR) && (addr <= HIGH_ADDR);
    assign ack = (state_q == ST_ACK);

    // HOLD waits for select to drop so a long select cannot produce a second ack
    always_comb begin
        state_nxt   = state_q;
        load_strobe = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_nxt   = ST_ACK;
                    load_strobe = 1'b1;
                end
            end
            ST_ACK:  state_nxt = ST_HOLD;
            ST_HOLD: if (!select) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rnw_q      <= 1'b0;
            word_off_q <= 2'd0;
        end else begin
            state_q <= state_nxt;
            if (load_strobe) begin
                rnw_q      <= rnw;
                word_off_q <= addr[3:2];
            end
        end
    end

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// rtl/opb_register_simulink2ppc_snap.sv - user-to-PPC snapshot register with read-to-pop on OPB
module opb_register_simulink2ppc_snap
    import opb_register_simulink2ppc_snap_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100B100,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100B1FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6"
)(
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid,
    output logic                    user_ready
);

    logic [31:0] abus, dbus;
    logic        load_strobe, ack, rnw_q;
    logic [1:0]  word_off_q;

    logic [31:0]        data_q, data_nxt;
    logic               valid_q, valid_nxt;
    logic               ovf_q, ovf_nxt;
    logic               armed_q, armed_nxt;
    logic [COUNT_W-1:0] count_q, count_nxt;

    logic [31:0] rd_q, rd_mux, status_word;
    logic        rd_was_valid_q;
    logic [1:0]  ctrl_wdata_q;
    logic        ctrl_be_q;
    logic        pop, ctrl_wr, ctrl_clear;
    logic        unused_bits;

    // register bit i sits on bus bit 31-i, which plain vector assignment gives
    assign abus = OPB_ABus;
    assign dbus = OPB_DBus;
    assign unused_bits = ^{OPB_seqAddr, OPB_BE[0:2], dbus[31:2]};

    opb_slave_ack_fsm #(
        .BASE_ADDR (C_BASEADDR),
        .HIGH_ADDR (C_HIGHADDR)
    ) u_ack_fsm (
        .clk         (OPB_Clk),
        .rst         (OPB_Rst),
        .select      (OPB_select),
        .addr        (abus),
        .rnw         (OPB_RNW),
        .load_strobe (load_strobe),
        .ack         (ack),
        .rnw_q       (rnw_q),
        .word_off_q  (word_off_q)
    );

    always_comb begin
        status_word                                = '0;
        status_word[STAT_VALID_BIT]                = valid_q;
        status_word[STAT_OVF_BIT]                  = ovf_q;
        status_word[STAT_ARMED_BIT]                = armed_q;
        status_word[STAT_COUNT_LSB +: COUNT_W]     = count_q;
    end

    always_comb begin
        rd_mux = '0;
        unique case (abus[3:2])
            WORD_DATA:   rd_mux = data_q;
            WORD_STATUS: rd_mux = status_word;
            default:     rd_mux = '0;
        endcase
    end

    // pop only if the word handed to the reader was actually valid, so a capture
    // landing on the decode edge is not discarded by the following ack
    assign pop        = ack && rnw_q && (word_off_q == WORD_DATA) && rd_was_valid_q;
    assign ctrl_wr    = ack && !rnw_q && (word_off_q == WORD_CTRL) && ctrl_be_q;
    assign ctrl_clear = ctrl_wr && ctrl_wdata_q[CTRL_CLEAR_BIT];

    always_comb begin
        data_nxt  = data_q;
        valid_nxt = valid_q;
        ovf_nxt   = ovf_q;
        armed_nxt = armed_q;
        count_nxt = count_q;
        if (ctrl_wr) armed_nxt = ctrl_wdata_q[CTRL_ARM_BIT];
        if (ctrl_clear) begin
            valid_nxt = 1'b0;
            ovf_nxt   = 1'b0;
            count_nxt = '0;
        end else if (armed_q && user_valid && (!valid_q || pop)) begin
            data_nxt  = user_data_in;
            valid_nxt = 1'b1;
            count_nxt = count_q + 1'b1;
        end else begin
            if (armed_q && user_valid) ovf_nxt = 1'b1;
            if (pop) valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            data_q         <= '0;
            valid_q        <= 1'b0;
            ovf_q          <= 1'b0;
            armed_q        <= 1'b0;
            count_q        <= '0;
            rd_q           <= '0;
            rd_was_valid_q <= 1'b0;
            ctrl_wdata_q   <= 2'd0;
            ctrl_be_q      <= 1'b0;
        end else begin
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            ovf_q   <= ovf_nxt;
            armed_q <= armed_nxt;
            count_q <= count_nxt;
            if (load_strobe) begin
                rd_q           <= OPB_RNW ? rd_mux : 32'd0;
                rd_was_valid_q <= valid_q;
                ctrl_wdata_q   <= dbus[1:0];
                ctrl_be_q      <= OPB_BE[3];
            end
        end
    end

    assign Sl_DBus    = ack ? rd_q : '0;
    assign Sl_xferAck = ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign user_ready = armed_q && !valid_q;

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// tb/tb_opb_register_simulink2ppc_snap.sv - self-checking bench for opb_register_simulink2ppc_snap
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE     = 32'h0100B100;
    localparam logic [31:0] HIGH     = 32'h0100B1FF;
    localparam logic [31:0] A_DATA   = BASE;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_CTRL   = BASE + 32'h8;
    localparam logic [31:0] A_RSVD   = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus;
    logic        rnw, sel, seq;
    logic [0:31] sl_dbus;
    logic        xack, errack, retry, tsup;
    logic [31:0] ud;
    logic        uv, ur;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_data;
    bit          m_valid, m_ovf, m_armed;
    int          m_count;

    always #5 clk = ~clk;

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .OPB_ABus     (abus),
        .OPB_BE       (be),
        .OPB_DBus     (dbus),
        .OPB_RNW      (rnw),
        .OPB_select   (sel),
        .OPB_seqAddr  (seq),
        .Sl_DBus      (sl_dbus),
        .Sl_xferAck   (xack),
        .Sl_errAck    (errack),
        .Sl_retry     (retry),
        .Sl_toutSup   (tsup),
        .user_data_in (ud),
        .user_valid   (uv),
        .user_ready   (ur)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] m_status();
        return {m_count[15:0], 13'd0, m_armed, m_ovf, m_valid};
    endfunction

    task automatic model_reset();
        m_data = 0; m_valid = 0; m_ovf = 0; m_armed = 0; m_count = 0;
    endtask

    task automatic model_offer(input logic [31:0] w);
        if (m_armed) begin
            if (!m_valid) begin
                m_data = w; m_valid = 1; m_count++;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic model_read_data(output logic [31:0] w);
        w = m_data;
        m_valid = 0;
    endtask

    task automatic model_ctrl(input logic [31:0] w, input logic [0:3] bev);
        if (bev[3]) begin
            m_armed = w[0];
            if (w[1]) begin m_valid = 0; m_ovf = 0; m_count = 0; end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int lat);
        lat = -1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (xack) begin lat = i; break; end
        end
    endtask

    task automatic bus_xfer(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [0:3] bev, output logic [31:0] rdata, output int lat);
        rnw = rd; abus = addr; dbus = wd; be = bev; sel = 1'b1;
        rdata = 32'hxxxxxxxx;
        wait_ack(lat);
        if (lat > 0) rdata = sl_dbus;
        sel = 1'b0; rnw = 1'b0; abus = '0; dbus = '0; be = '0;
        tick();
        tick();
    endtask

    task automatic rd_reg(input logic [31:0] addr, output logic [31:0] v);
        int lat;
        bus_xfer(1'b1, addr, 32'd0, 4'hF, v, lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL rd_latency addr=%h got=%0d exp=1", addr, lat);
        end
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] w, input logic [0:3] bev);
        int lat;
        logic [31:0] v;
        bus_xfer(1'b0, addr, w, bev, v, lat);
        checks++;
        if (lat != 1 || v !== 32'd0) begin
            errors++;
            $display("FAIL wr_ack addr=%h lat=%0d dbus=%h exp lat=1 dbus=0", addr, lat, v);
        end
    endtask

    task automatic offer(input logic [31:0] w);
        uv = 1'b1; ud = w;
        tick();
        uv = 1'b0; ud = '0;
        model_offer(w);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (xack !== 1'b0 || sl_dbus !== 32'd0 || ur !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs ack=%b dbus=%h ready=%b exp 0/0/0", xack, sl_dbus, ur);
        end
        checks++;
        if ({errack, retry, tsup} !== 3'b000) begin
            errors++;
            $display("FAIL tied_outputs got=%b exp=000", {errack, retry, tsup});
        end
        rst = 1'b0;
        tick();
        model_reset();
        rd_reg(A_STATUS, v);
        checks++;
        if (v !== 32'h0 || ur !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got=%h ready=%b exp=00000000 ready=0", v, ur);
        end
    endtask

    task automatic test_capture();
        logic [31:0] v;
        wr_reg(A_CTRL, 32'h1, 4'hF);
        model_ctrl(32'h1, 4'hF);
        checks++;
        if (ur !== 1'b1) begin errors++; $display("FAIL armed_ready got=%b exp=1", ur); end
        offer(32'hDEADBEEF);
        checks++;
        if (ur !== 1'b0) begin errors++; $display("FAIL ready_drop got=%b exp=0", ur); end
        rd_reg(A_STATUS, v);
        checks++;
        if (v !== 32'h00010005) begin errors++; $display("FAIL capture_status got=%h exp=00010005", v); end
        rd_reg(A_DATA, v);
        model_read_data(m_data);
        checks++;
        if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL capture_data got=%h exp=deadbeef", v); end
        rd_reg(A_STATUS, v);
        checks++;
        if (v !== 32'h00010004) begin errors++; $display("FAIL pop_status got=%h exp=00010004", v); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        offer(32'h11111111);
        offer(32'h12345678);
        rd_reg(A_DATA, v);
        checks++;
        if (v !== 32'h11111111) begin errors++; $display("FAIL ovf_data got=%h exp=11111111", v); end
        rd_reg(A_STATUS, v);
        checks++;
        if (v !== 32'h00020006) begin errors++; $display("FAIL ovf_status got=%h exp=00020006", v); end
        wr_reg(A_CTRL, 32'h3, 4'hF);
        rd_reg(A_STATUS, v);
        checks++;
        if (v !== 32'h00000004) begin errors++; $display("FAIL clear_status got=%h exp=00000004", v); end
        model_reset();
        m_armed = 1;
    endtask

    task automatic test_simultaneous();
        logic [31:0] v, old_word;
        int lat;
        offer(32'hAAAA5555);
        rnw = 1'b1; abus = A_DATA; be = 4'hF; sel = 1'b1;
        wait_ack(lat);
        v = sl_dbus;
        uv = 1'b1; ud = 32'hCAFEF00D; sel = 1'b0;
        tick();
        uv = 1'b0; rnw = 1'b0;
        tick();
        model_read_data(old_word);
        model_offer(32'hCAFEF00D);
        checks++;
        if (lat != 1 || v !== old_word) begin
            errors++;
            $display("FAIL simul_read got=%h lat=%0d exp=%h lat=1", v, lat, old_word);
        end
        rd_reg(A_DATA, v);
        checks++;
        if (v !== 32'hCAFEF00D) begin errors++; $display("FAIL simul_next got=%h exp=cafef00d", v); end
        model_read_data(old_word);
        rd_reg(A_STATUS, v);
        checks++;
        if (v !== 32'h00020004) begin errors++; $display("FAIL simul_status got=%h exp=00020004", v); end

        rnw = 1'b0; abus = A_CTRL; dbus = 32'h3; be = 4'hF; sel = 1'b1;
        wait_ack(lat);
        uv = 1'b1; ud = 32'h0BADF00D; sel = 1'b0;
        tick();
        uv = 1'b0; dbus = '0;
        tick();
        model_ctrl(32'h3, 4'hF);
        rd_reg(A_STATUS, v);
        checks++;
        if (lat != 1 || v !== 32'h00000004 || ur !== 1'b1) begin
            errors++;
            $display("FAIL clear_wins got=%h ready=%b lat=%0d exp=00000004 ready=1 lat=1", v, ur, lat);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        rnw = 1'b1; abus = A_STATUS; be = 4'hF; sel = 1'b1;
        n = 0;
        repeat (6) begin
            tick();
            if (xack) n++;
        end
        sel = 1'b0; rnw = 1'b0;
        tick();
        tick();
        checks++;
        if (n != 1) begin errors++; $display("FAIL held_select acks got=%0d exp=1", n); end
    endtask

    task automatic test_boundaries();
        logic [31:0] v;
        int lat;
        offer(32'h5A5A0001);
        rd_reg(HIGH - 32'h3, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL high_word got=%h exp=00000000", v); end
        rd_reg(A_RSVD, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL rsvd_read got=%h exp=00000000", v); end
        bus_xfer(1'b1, BASE - 32'h4, 32'd0, 4'hF, v, lat);
        checks++;
        if (lat != -1) begin errors++; $display("FAIL miss_below lat=%0d exp=-1", lat); end
        bus_xfer(1'b1, HIGH + 32'h1, 32'd0, 4'hF, v, lat);
        checks++;
        if (lat != -1) begin errors++; $display("FAIL miss_above lat=%0d exp=-1", lat); end
        wr_reg(A_DATA, 32'hFFFFFFFF, 4'hF);
        wr_reg(A_STATUS, 32'hFFFFFFFF, 4'hF);
        wr_reg(A_RSVD, 32'hFFFFFFFF, 4'hF);
        wr_reg(A_CTRL, 32'h2, 4'b1110);
        model_ctrl(32'h2, 4'b1110);
        rd_reg(A_STATUS, v);
        checks++;
        if (v !== m_status()) begin errors++; $display("FAIL ignored_writes got=%h exp=%h", v, m_status()); end
        rd_reg(A_DATA, v);
        checks++;
        if (v !== m_data) begin errors++; $display("FAIL ignored_data got=%h exp=%h", v, m_data); end
        model_read_data(m_data);
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int lat, n;
        offer(32'h77778888);
        rnw = 1'b0; abus = A_CTRL; dbus = 32'h1; be = 4'hF; sel = 1'b1;
        wait_ack(lat);
        rst = 1'b1; sel = 1'b0;
        tick();
        rst = 1'b0; dbus = '0;
        model_reset();
        n = 0;
        repeat (4) begin
            if (xack) n++;
            tick();
        end
        checks++;
        if (n != 0 || ur !== 1'b0 || sl_dbus !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid acks=%0d ready=%b dbus=%h exp 0/0/0", n, ur, sl_dbus);
        end
        rd_reg(A_STATUS, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_mid_status got=%h exp=00000000", v); end
        rd_reg(A_DATA, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_mid_data got=%h exp=00000000", v); end
    endtask

    task automatic test_count_wrap();
        logic [31:0] v;
        wr_reg(A_CTRL, 32'h3, 4'hF);
        model_ctrl(32'h3, 4'hF);
        force dut.count_q = 16'hFFFF;
        tick();
        release dut.count_q;
        m_count = 65535;
        rd_reg(A_STATUS, v);
        checks++;
        if (v !== 32'hFFFF0004) begin errors++; $display("FAIL preload_status got=%h exp=ffff0004", v); end
        offer(32'h00C0FFEE);
        rd_reg(A_STATUS, v);
        checks++;
        if (v !== 32'h00000005) begin errors++; $display("FAIL count_wrap got=%h exp=00000005", v); end
        m_count = m_count % 65536;
    endtask

    task automatic test_random();
        logic [31:0] v, e, w;
        logic [0:3]  bev;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0, 1: offer($urandom);
                2: begin
                    rd_reg(A_DATA, v);
                    model_read_data(e);
                    checks++;
                    if (v !== e) begin errors++; $display("FAIL rand_data it=%0d got=%h exp=%h", i, v, e); end
                end
                3: begin
                    rd_reg(A_STATUS, v);
                    checks++;
                    if (v !== m_status()) begin
                        errors++;
                        $display("FAIL rand_status it=%0d got=%h exp=%h", i, v, m_status());
                    end
                end
                4: begin
                    w   = $urandom;
                    w[1] = ($urandom_range(0, 5) == 0);
                    w[0] = ($urandom_range(0, 3) != 0);
                    bev = 4'($urandom);
                    wr_reg(A_CTRL, w, bev);
                    model_ctrl(w, bev);
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        rd_reg(A_RSVD, v);
                        checks++;
                        if (v !== 32'h0) begin errors++; $display("FAIL rand_rsvd it=%0d got=%h exp=0", i, v); end
                    end else begin
                        wr_reg(($urandom_range(0, 1) == 1) ? A_DATA : A_STATUS, $urandom, 4'hF);
                    end
                end
            endcase
            checks++;
            if (ur !== (m_armed && !m_valid)) begin
                errors++;
                $display("FAIL rand_ready it=%0d got=%b exp=%b", i, ur, m_armed && !m_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b1; abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel = 1'b0; seq = 1'b0;
        ud = '0; uv = 1'b0;
        model_reset();
        test_reset();
        test_capture();
        test_overflow();
        test_simultaneous();
        test_back_to_back();
        test_boundaries();
        test_random();
        test_reset_mid();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
